// File: rtl/spectrum_height_writer.sv
// Reduces a stream of FFT bin magnitudes to per-band bar heights and publishes
// whole frames on the video update pulse. Optional macro PEAK_DECAY_EN: bars fall gradually.
module spectrum_height_writer #(
  parameter int NUM_BANDS     = 16,
  parameter int BINS_PER_BAND = 16,
  parameter int MAG_W         = 16,
  parameter int HEIGHT_W      = 9,
  parameter int MAX_HEIGHT    = 479,
  parameter int SHIFT         = 7,
  parameter int DECAY_STEP    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [MAG_W-1:0]              s_mag,
  input  logic                          s_last,
  input  logic                          update,
  output logic [NUM_BANDS*HEIGHT_W-1:0] heights,
  output logic                          loaded,
  output logic                          overrun
);

  localparam int BIN_W  = (BINS_PER_BAND > 1) ? $clog2(BINS_PER_BAND) : 1;
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

`ifdef PEAK_DECAY_EN
  localparam int FALL = DECAY_STEP;
`else
  // A full-scale falloff always saturates to 0, so each publish is a plain copy.
  localparam int FALL = (DECAY_STEP < 0) ? 0 : (1 << HEIGHT_W) - 1;
`endif
  localparam logic [HEIGHT_W-1:0] FALL_V = HEIGHT_W'(FALL);

  typedef enum logic [1:0] {ACCUM, FILL, READY} state_t;

  state_t              state_reg, state_next;
  logic [BIN_W-1:0]    bin_cnt_reg, bin_cnt_next;
  logic [BAND_W-1:0]   band_cnt_reg, band_cnt_next;
  logic [MAG_W-1:0]    peak_reg, peak_next;
  logic                loaded_reg, overrun_reg;

  logic                accept, last_bin, last_band;
  logic [MAG_W-1:0]    band_max, shifted;
  logic [HEIGHT_W-1:0] h_clamp, stage_data;
  logic                stage_wr, publish, overrun_set;

  assign accept    = s_valid && s_ready;
  assign last_bin  = (bin_cnt_reg == BIN_W'(BINS_PER_BAND - 1));
  assign last_band = (band_cnt_reg == BAND_W'(NUM_BANDS - 1));
  assign band_max  = (s_mag > peak_reg) ? s_mag : peak_reg;
  assign shifted   = band_max >> SHIFT;
  assign h_clamp   = (shifted > MAG_W'(MAX_HEIGHT)) ? HEIGHT_W'(MAX_HEIGHT)
                                                    : shifted[HEIGHT_W-1:0];
  // READY back-pressures the source, so a finished frame can never be replaced.
  assign overrun_set = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ACCUM;
      bin_cnt_reg  <= '0;
      band_cnt_reg <= '0;
      peak_reg     <= '0;
      loaded_reg   <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_cnt_reg  <= bin_cnt_next;
      band_cnt_reg <= band_cnt_next;
      peak_reg     <= peak_next;
      loaded_reg   <= publish;
      overrun_reg  <= overrun_reg | overrun_set;
    end
  end

  always_comb begin
    state_next    = state_reg;
    s_ready       = 1'b0;
    bin_cnt_next  = bin_cnt_reg;
    band_cnt_next = band_cnt_reg;
    peak_next     = peak_reg;
    stage_wr      = 1'b0;
    stage_data    = h_clamp;
    publish       = 1'b0;
    case (state_reg)
      ACCUM: begin
        s_ready = 1'b1;
        if (accept) begin
          if (last_bin || s_last) begin
            stage_wr     = 1'b1;
            peak_next    = '0;
            bin_cnt_next = '0;
            if (last_band) begin
              state_next = READY;
            end else begin
              band_cnt_next = band_cnt_reg + BAND_W'(1);
              if (s_last) state_next = FILL;
            end
          end else begin
            peak_next    = band_max;
            bin_cnt_next = bin_cnt_reg + BIN_W'(1);
          end
        end
      end
      FILL: begin
        stage_wr   = 1'b1;
        stage_data = '0;
        if (last_band) state_next = READY;
        else band_cnt_next = band_cnt_reg + BAND_W'(1);
      end
      READY: begin
        if (update) begin
          publish       = 1'b1;
          bin_cnt_next  = '0;
          band_cnt_next = '0;
          peak_next     = '0;
          state_next    = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
      logic [HEIGHT_W-1:0] staging_reg, height_reg, fallen, pub_val;

      assign fallen  = (height_reg > FALL_V) ? height_reg - FALL_V : '0;
      assign pub_val = (staging_reg > fallen) ? staging_reg : fallen;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          staging_reg <= '0;
          height_reg  <= '0;
        end else begin
          if (stage_wr && band_cnt_reg == BAND_W'(gi)) staging_reg <= stage_data;
          if (publish) height_reg <= pub_val;
        end
      end

      assign heights[gi*HEIGHT_W +: HEIGHT_W] = height_reg;
    end
  endgenerate

  assign loaded  = loaded_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_spectrum_height_writer.sv
// Directed self-checking bench for spectrum_height_writer (default parameters).
module tb_spectrum_height_writer;

  localparam int NB = 16;
  localparam int HW = 9;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              s_valid, s_ready, s_last, update, loaded, overrun;
  logic [15:0]       s_mag;
  logic [NB*HW-1:0]  heights;

  int total = 0;
  int bad   = 0;
  logic [HW-1:0] exp_h [NB];

  spectrum_height_writer dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_mag(s_mag), .s_last(s_last), .update(update), .heights(heights),
    .loaded(loaded), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] get_h(input int i);
    return heights[i*HW +: HW];
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_sample(input logic [15:0] mag, input logic last);
    int w = 0;
    while (s_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (s_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout s_ready=%b required=1", s_ready);
    end
    s_valid = 1'b1; s_mag = mag; s_last = last;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_const_frame(input logic [15:0] mag);
    for (int i = 0; i < 256; i++) send_sample(mag, i == 255);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_valid = 1'b0; s_mag = '0; s_last = 1'b0; update = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (heights !== '0) begin bad++; $display("FAIL reset_heights got=%h want=0", heights); end
    total++;
    if (loaded !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL reset_flags loaded=%b overrun=%b want=0/0", loaded, overrun);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", s_ready); end
    $display("test_reset: done");
  endtask

  task automatic test_constant();
    send_const_frame(16'h1000);
    total++;
    if (s_ready !== 1'b0 || loaded !== 1'b0 || heights !== '0) begin
      bad++; $display("FAIL const_prepub ready=%b loaded=%b heights=%h want 0/0/0", s_ready, loaded, heights);
    end
    update = 1'b1; @(negedge clk); update = 1'b0;
    total++;
    if (loaded !== 1'b1) begin bad++; $display("FAIL const_loaded got=%b want=1", loaded); end
    for (int i = 0; i < NB; i++) begin
      total++;
      if (get_h(i) !== 9'd32) begin bad++; $display("FAIL const_h%0d got=%0d want=32", i, get_h(i)); end
    end
    @(negedge clk);
    total++;
    if (loaded !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL const_after loaded=%b ready=%b want 0/1", loaded, s_ready);
    end
    $display("test_constant: done");
  endtask

  task automatic test_clamp();
    do_reset();
    for (int i = 0; i < 256; i++) send_sample((i == 3*16 + 5) ? 16'hFFFF : 16'h0000, i == 255);
    update = 1'b1; @(negedge clk); update = 1'b0;
    for (int i = 0; i < NB; i++) begin
      total++;
      if (get_h(i) !== ((i == 3) ? 9'd479 : 9'd0)) begin
        bad++; $display("FAIL clamp_h%0d got=%0d want=%0d", i, get_h(i), (i == 3) ? 479 : 0);
      end
    end
    @(negedge clk);
    $display("test_clamp: done");
  endtask

  task automatic test_early_last();
    int ready_bad = 0;
    int load_bad = 0;
    do_reset();
    for (int i = 0; i <= 40; i++)
      send_sample((i < 32) ? 16'h0280 : ((i == 35) ? 16'h0800 : 16'h0100), i == 40);
    // Twelve FILL cycles; an update during FILL must be ignored.
    for (int j = 0; j < 12; j++) begin
      if (s_ready !== 1'b0) ready_bad++;
      if (loaded !== 1'b0) load_bad++;
      update = (j == 1);
      @(negedge clk);
    end
    update = 1'b0;
    total++;
    if (ready_bad != 0 || load_bad != 0) begin
      bad++; $display("FAIL early_fill ready_high=%0d loaded_high=%0d want 0/0", ready_bad, load_bad);
    end
    // Update arriving on the edge that enters READY is not seen.
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL early_fill_end ready=%b want=0", s_ready); end
    update = 1'b1; @(negedge clk);
    total++;
    if (loaded !== 1'b0 || s_ready !== 1'b0) begin
      bad++; $display("FAIL early_enter_ready loaded=%b ready=%b want 0/0", loaded, s_ready);
    end
    @(negedge clk); update = 1'b0;
    total++;
    if (loaded !== 1'b1) begin bad++; $display("FAIL early_loaded got=%b want=1", loaded); end
    for (int i = 0; i < NB; i++) exp_h[i] = '0;
    exp_h[0] = 9'd5; exp_h[1] = 9'd5; exp_h[2] = 9'd16;
    for (int i = 0; i < NB; i++) begin
      total++;
      if (get_h(i) !== exp_h[i]) begin bad++; $display("FAIL early_h%0d got=%0d want=%0d", i, get_h(i), exp_h[i]); end
    end
    @(negedge clk);
    $display("test_early_last: done");
  endtask

  task automatic test_back_to_back();
    int viol = 0;
    do_reset();
    send_const_frame(16'h2000);
    s_valid = 1'b1; s_mag = 16'h1234;
    for (int c = 0; c < 1000; c++) begin
      if (s_ready !== 1'b0 || loaded !== 1'b0 || heights !== '0) viol++;
      @(negedge clk);
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL backpressure violating_cycles=%0d want=0", viol); end
    update = 1'b1; @(negedge clk); update = 1'b0;
    total++;
    if (loaded !== 1'b1 || s_ready !== 1'b1) begin
      bad++; $display("FAIL bp_publish loaded=%b ready=%b want 1/1", loaded, s_ready);
    end
    s_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      total++;
      if (get_h(i) !== 9'd64) begin bad++; $display("FAIL bp_h%0d got=%0d want=64", i, get_h(i)); end
    end
    @(negedge clk);
    total++;
    if (loaded !== 1'b0) begin bad++; $display("FAIL bp_pulse_width loaded=%b want=0", loaded); end
    $display("test_back_to_back: done");
  endtask

  task automatic test_update_ignored();
    for (int i = 0; i < 20; i++) send_sample(16'h4000, 1'b0);
    update = 1'b1; @(negedge clk); update = 1'b0;
    total++;
    if (loaded !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL ign_flags loaded=%b ready=%b want 0/1", loaded, s_ready);
    end
    total++;
    if (get_h(0) !== 9'd64 || get_h(15) !== 9'd64) begin
      bad++; $display("FAIL ign_heights h0=%0d h15=%0d want 64/64", get_h(0), get_h(15));
    end
    for (int i = 0; i < 7; i++) send_sample(16'h4000, 1'b0);
    reset_n = 1'b0;
    #1;
    total++;
    if (heights !== '0) begin bad++; $display("FAIL midreset_heights got=%h want=0", heights); end
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", s_ready); end
    send_const_frame(16'h1000);
    update = 1'b1; @(negedge clk); update = 1'b0;
    total++;
    if (loaded !== 1'b1 || get_h(0) !== 9'd32 || get_h(15) !== 9'd32) begin
      bad++; $display("FAIL postreset_frame loaded=%b h0=%0d h15=%0d want 1/32/32", loaded, get_h(0), get_h(15));
    end
    @(negedge clk);
    $display("test_update_ignored: done");
  endtask

  task automatic test_decay();
    logic [HW-1:0] want1, want2;
`ifdef PEAK_DECAY_EN
    want1 = 9'd96; want2 = 9'd92;
`else
    want1 = 9'd0;  want2 = 9'd0;
`endif
    send_const_frame(16'h3200);
    update = 1'b1; @(negedge clk); update = 1'b0;
    total++;
    if (get_h(7) !== 9'd100) begin bad++; $display("FAIL decay_h100 got=%0d want=100", get_h(7)); end
    send_const_frame(16'h0000);
    update = 1'b1; @(negedge clk); update = 1'b0;
    total++;
    if (get_h(7) !== want1 || get_h(0) !== want1) begin
      bad++; $display("FAIL decay_step1 h7=%0d h0=%0d want=%0d", get_h(7), get_h(0), want1);
    end
    send_const_frame(16'h0000);
    update = 1'b1; @(negedge clk); update = 1'b0;
    total++;
    if (get_h(7) !== want2) begin bad++; $display("FAIL decay_step2 got=%0d want=%0d", get_h(7), want2); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun got=%b want=0", overrun); end
    @(negedge clk);
    $display("test_decay: done");
  endtask

  initial begin
    test_reset();
    test_constant();
    test_clamp();
    test_early_last();
    test_back_to_back();
    test_update_ignored();
    test_decay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
